lamp_driver: RTL and testbench
==============================

Name: lamp_driver

Overview:
- Output-side counterpart of the button debouncer: drives the physical traffic-light lamps (LEDs) from fabric-level commands.
- Per lamp: off, on, blink, or anti-phase blink, with common PWM brightness.
- Command updates go through a shadow register and are applied only at PWM frame boundaries, so outputs never glitch.
- Sits between the traffic-light FSM and the board LED pins.

Parameters:
- C_CLK_FRQ, 100_000_000, clock frequency [Hz].
- C_PWM_FRQ, 1000, PWM frame rate [Hz].
- C_DUTY_W, 8, duty/PWM counter width [bits].
- C_BLINK_MS, 500, blink half-period [ms].
- C_LAMPS, 3, number of lamps.
- Derived C_STEP = max(1, C_CLK_FRQ / (C_PWM_FRQ * 2^C_DUTY_W)), integer division.
- Derived C_BLINK_CYC = C_CLK_FRQ * C_BLINK_MS / 1000.

Ports:
- clk  in  1  master clock.
- rstb  in  1  synchronous reset, active-high.
- load  in  1  single-cycle strobe; captures mode/duty.
- mode  in  2*C_LAMPS  per-lamp mode, lamp i at bits [2i+1:2i]: 00 off, 01 on, 10 blink, 11 blink-inverted.
- duty  in  C_DUTY_W  common brightness.
- ack  out  1  one-cycle pulse when a pending command becomes active.
- frame  out  1  one-cycle pulse at each PWM frame start.
- lamp  out  C_LAMPS  lamp drive, active-high.

Behaviour:
- Reset (rstb=1 at posedge), effective next edge; overrides everything, including mid-operation:
  - lamp=0, ack=0, frame=0, pending=0.
  - Shadow and active modes = 00; shadow and active duty = all-ones.
  - Prescaler, PWM counter, blink counter = 0; blink phase = 0.
- Prescaler: counts 0..C_STEP-1 and wraps. tick=1 on the cycle it equals C_STEP-1.
- PWM counter (C_DUTY_W bits): increments on tick; wraps max→0.
- frame_start = tick AND PWM counter == max. Registered `frame` output equals frame_start delayed 1 cycle.
- pwm_on = (active duty == all-ones) OR (PWM counter < active duty):
  - duty 0 → never on.
  - duty all-ones → always on.
  - otherwise on for exactly duty steps per frame.
- Blink: free-running counter 0..C_BLINK_CYC-1. At terminal count it wraps and toggles the phase. Independent of PWM and of load.
- Lamp i is registered (1-cycle latency from counter state):
  - 00 → 0
  - 01 → pwm_on
  - 10 → pwm_on AND phase
  - 11 → pwm_on AND NOT phase
- Load handshake:
  - load=1 copies mode/duty into shadow and sets pending=1.
  - Repeated loads before a frame boundary overwrite the shadow (last wins); only one ack results.
- Apply:
  - On a frame_start cycle with pending=1: active ← shadow, pending ← 0, ack=1 on the next cycle.
  - The new values govern lamps from PWM count 0 of the new frame.
- Load in the same cycle as frame_start:
  - The previously pending shadow (if any) is applied.
  - The new data is captured into shadow and pending stays 1; it is applied at the following frame.
  - If nothing was pending, no ack this frame.
- load with rstb=1: ignored.
- Widths: counters sized with $clog2 of their terminal values (minimum 1 bit). No other arithmetic overflow is possible.

Test Plan:
Bench parameters: C_CLK_FRQ=25600, C_PWM_FRQ=100, C_DUTY_W=8, C_BLINK_MS=100, C_LAMPS=3, giving C_STEP=1, 256-cycle frames, and C_BLINK_CYC=2560.
1. Reset, then no load for 6000 cycles → lamp=000, ack never asserted, frame pulses every 256 cycles.
2. load with mode=010101, duty=64 → exactly one ack, at the first frame boundary; thereafter each lamp is high 64 consecutive cycles per 256-cycle frame.
3. Mode all-on with duty=0 → lamp=000 constant; then load duty=255 → lamp=111 constant after the next frame boundary.
4. Lamp0 mode 10, lamp1 mode 11, duty=255 → lamp0 and lamp1 strictly complementary, each toggling every 2560 cycles; lamp2 stays 0.
5. Two loads within one frame (duty 32, then duty 200) → single ack, active duty=200. Separately, load coincident with frame_start → applied one frame later.
6. rstb=1 mid-blink with a load pending → next cycle lamp=0, ack=0; after release, lamps stay off and no ack occurs (pending discarded).

Source files
------------

// File: rtl/lamp_driver.sv
// lamp_driver
//   Drives the traffic-light lamps from fabric-level commands. Each lamp is
//   off, on, blinking or blinking in anti-phase, and all lamps share one PWM
//   brightness. New commands land in a shadow register. They are copied to the
//   active register only at a PWM frame boundary, so lamp waveforms never glitch.
//
// Ports
//   clk    master clock
//   rstb   synchronous reset, active-high
//   load   single-cycle strobe, captures mode/duty into the shadow register
//   mode   per-lamp mode, lamp i at [2i+1:2i]: 00 off, 01 on, 10 blink, 11 blink-inverted
//   duty   common brightness (all-ones = fully on, 0 = off)
//   ack    one-cycle pulse when a pending command becomes active
//   frame  one-cycle pulse at each PWM frame start (registered)
//   lamp   lamp drive, active-high
module lamp_driver #(
    parameter int unsigned C_CLK_FRQ  = 100_000_000,
    parameter int unsigned C_PWM_FRQ  = 1000,
    parameter int unsigned C_DUTY_W   = 8,
    parameter int unsigned C_BLINK_MS = 500,
    parameter int unsigned C_LAMPS    = 3
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   load,
    input  logic [2*C_LAMPS-1:0]   mode,
    input  logic [C_DUTY_W-1:0]    duty,
    output logic                   ack,
    output logic                   frame,
    output logic [C_LAMPS-1:0]     lamp
);

    // Derived timing constants; 64-bit so CLK_FRQ * BLINK_MS cannot overflow.
    localparam longint unsigned C_STEP_RAW  = 64'(C_CLK_FRQ) / (64'(C_PWM_FRQ) * (64'd1 << C_DUTY_W));
    localparam longint unsigned C_STEP      = (C_STEP_RAW < 64'd1) ? 64'd1 : C_STEP_RAW;
    localparam longint unsigned C_BLINK_CYC = 64'(C_CLK_FRQ) * 64'(C_BLINK_MS) / 64'd1000;

    localparam int unsigned PRE_W = ($clog2(C_STEP) < 1) ? 1 : $clog2(C_STEP);
    localparam int unsigned BLK_W = ($clog2(C_BLINK_CYC) < 1) ? 1 : $clog2(C_BLINK_CYC);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(C_STEP - 64'd1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(C_BLINK_CYC - 64'd1);

    logic [PRE_W-1:0]      presc;
    logic [C_DUTY_W-1:0]   pwm_cnt;
    logic [BLK_W-1:0]      blink_cnt;
    logic                  phase;

    logic [2*C_LAMPS-1:0]  mode_shd;
    logic [2*C_LAMPS-1:0]  mode_act;
    logic [C_DUTY_W-1:0]   duty_shd;
    logic [C_DUTY_W-1:0]   duty_act;
    logic                  pending;

    logic                  tick;
    logic                  frame_start;
    logic                  pwm_on;
    logic [C_LAMPS-1:0]    lamp_nxt;

    always_comb begin
        tick        = (presc == PRE_LAST);
        frame_start = tick && (pwm_cnt == '1);
        // Full-scale duty short-circuits the compare so all-ones means 100 %.
        pwm_on      = (duty_act == '1) || (pwm_cnt < duty_act);

        lamp_nxt = '0;
        for (int unsigned i = 0; i < C_LAMPS; i++) begin
            case (mode_act[2*i +: 2])
                2'b01:   lamp_nxt[i] = pwm_on;
                2'b10:   lamp_nxt[i] = pwm_on && phase;
                2'b11:   lamp_nxt[i] = pwm_on && !phase;
                default: lamp_nxt[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            presc     <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            mode_shd  <= '0;
            mode_act  <= '0;
            duty_shd  <= '1;
            duty_act  <= '1;
            pending   <= 1'b0;
            ack       <= 1'b0;
            frame     <= 1'b0;
            lamp      <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end

            if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                phase     <= !phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            frame <= frame_start;
            ack   <= frame_start && pending;

            // The apply uses the shadow value from before this cycle, so a
            // load coinciding with frame_start is held for the next frame.
            if (frame_start && pending) begin
                mode_act <= mode_shd;
                duty_act <= duty_shd;
            end

            if (load) begin
                mode_shd <= mode;
                duty_shd <= duty;
                pending  <= 1'b1;
            end else if (frame_start) begin
                pending  <= 1'b0;
            end

            lamp <= lamp_nxt;
        end
    end

endmodule

// File: tb/tb_lamp_driver.sv
// tb_lamp_driver
//   Directed bench for lamp_driver with a 256-cycle PWM frame and a
//   2560-cycle blink half-period. Timeline index t counts clock edges since
//   the last reset release; expected values are hand-derived from t.
module tb_lamp_driver;

    localparam int unsigned LAMPS = 3;

    logic             clk = 1'b0;
    logic             rstb;
    logic             load;
    logic [5:0]       mode;
    logic [7:0]       duty;
    logic             ack;
    logic             frame;
    logic [2:0]       lamp;

    always #5 clk = ~clk;

    lamp_driver #(
        .C_CLK_FRQ  (25600),
        .C_PWM_FRQ  (100),
        .C_DUTY_W   (8),
        .C_BLINK_MS (100),
        .C_LAMPS    (LAMPS)
    ) dut (
        .clk   (clk),
        .rstb  (rstb),
        .load  (load),
        .mode  (mode),
        .duty  (duty),
        .ack   (ack),
        .frame (frame),
        .lamp  (lamp)
    );

    int n_cmp = 0;
    int n_err = 0;
    int t     = 0;

    int frames, first_frame, last_frame, min_gap, max_gap;
    int acks, last_ack;
    int hi [3];
    int tog[3];
    int eq01;
    int run0, max_run0;
    logic [2:0] prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic clear_stats();
        frames = 0; first_frame = -1; last_frame = -1;
        min_gap = 1000000; max_gap = 0;
        acks = 0; last_ack = -1;
        eq01 = 0; run0 = 0; max_run0 = 0;
        for (int i = 0; i < 3; i++) begin
            hi[i]  = 0;
            tog[i] = 0;
        end
        prev = lamp;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            if (frame === 1'b1) begin
                frames++;
                if (first_frame < 0) first_frame = t;
                if (last_frame >= 0) begin
                    if (t - last_frame < min_gap) min_gap = t - last_frame;
                    if (t - last_frame > max_gap) max_gap = t - last_frame;
                end
                last_frame = t;
            end
            if (ack === 1'b1) begin
                acks++;
                last_ack = t;
            end
            for (int i = 0; i < 3; i++) begin
                if (lamp[i] === 1'b1) hi[i]++;
                if (lamp[i] !== prev[i]) tog[i]++;
            end
            if (lamp[0] === lamp[1]) eq01++;
            if (lamp[0] === 1'b1) begin
                run0++;
                if (run0 > max_run0) max_run0 = run0;
            end else begin
                run0 = 0;
            end
            prev = lamp;
        end
    endtask

    task automatic run_to(input int target);
        step(target - t);
    endtask

    task automatic load_cmd(input logic [5:0] m, input logic [7:0] d);
        mode = m;
        duty = d;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        rstb = 1'b1;
        load = 1'b0;
        mode = '0;
        duty = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_lamp",  32'(lamp),  32'd0);
        check("rst_ack",   32'(ack),   32'd0);
        check("rst_frame", 32'(frame), 32'd0);
        rstb = 1'b0;
        t = 0;
        clear_stats();

        // 1: idle after reset
        run_to(6000);
        check("idle_frames",    32'(frames),      32'd23);
        check("idle_first_frm", 32'(first_frame), 32'd256);
        check("idle_min_gap",   32'(min_gap),     32'd256);
        check("idle_max_gap",   32'(max_gap),     32'd256);
        check("idle_acks",      32'(acks),        32'd0);
        check("idle_lamp_hi",   32'(hi[0] + hi[1] + hi[2]), 32'd0);

        // 2: all on, duty 64
        clear_stats();
        load_cmd(6'b010101, 8'd64);
        run_to(6144);
        check("d64_acks",     32'(acks),     32'd1);
        check("d64_ack_t",    32'(last_ack), 32'd6144);
        check("d64_pre_hi",   32'(hi[0] + hi[1] + hi[2]), 32'd0);
        clear_stats();
        run_to(7168);
        check("d64_hi0",      32'(hi[0]),    32'd256);
        check("d64_hi1",      32'(hi[1]),    32'd256);
        check("d64_hi2",      32'(hi[2]),    32'd256);
        check("d64_tog0",     32'(tog[0]),   32'd8);
        check("d64_run0",     32'(max_run0), 32'd64);
        check("d64_no_ack",   32'(acks),     32'd0);

        // 3: duty 0 then duty 255
        clear_stats();
        load_cmd(6'b010101, 8'd0);
        run_to(7424);
        check("d0_acks",      32'(acks), 32'd1);
        clear_stats();
        run_to(7680);
        check("d0_hi",        32'(hi[0] + hi[1] + hi[2]), 32'd0);
        load_cmd(6'b010101, 8'd255);
        run_to(7936);
        check("d255_before",  32'(lamp), 32'd0);
        clear_stats();
        run_to(8448);
        check("d255_hi0",     32'(hi[0]), 32'd512);
        check("d255_hi1",     32'(hi[1]), 32'd512);
        check("d255_hi2",     32'(hi[2]), 32'd512);
        check("d255_lamp",    32'(lamp),  32'd7);

        // 4: blink / anti-phase blink
        load_cmd(6'b001110, 8'd255);
        run_to(10240);
        check("blk_10240",    32'(lamp), 32'd1);
        clear_stats();
        step(1);
        check("blk_10241",    32'(lamp), 32'd2);
        run_to(12800);
        check("blk_12800",    32'(lamp), 32'd2);
        step(1);
        check("blk_12801",    32'(lamp), 32'd1);
        run_to(15360);
        check("blk_tog0",     32'(tog[0]), 32'd2);
        check("blk_hi0",      32'(hi[0]),  32'd2560);
        check("blk_compl",    32'(eq01),   32'd0);
        check("blk_hi2",      32'(hi[2]),  32'd0);

        // 5a: two loads in one frame, last wins, single ack
        clear_stats();
        run_to(15369);
        load_cmd(6'b010101, 8'd32);
        run_to(15399);
        load_cmd(6'b010101, 8'd200);
        run_to(15616);
        check("dbl_acks",     32'(acks),     32'd1);
        check("dbl_ack_t",    32'(last_ack), 32'd15616);
        clear_stats();
        run_to(15872);
        check("dbl_hi0",      32'(hi[0]), 32'd200);
        check("dbl_no_ack",   32'(acks),  32'd0);

        // 5b: load coincident with frame_start while something is pending
        clear_stats();
        run_to(15899);
        load_cmd(6'b010101, 8'd100);
        run_to(16127);
        load_cmd(6'b010101, 8'd50);
        check("coin_acks",    32'(acks),     32'd1);
        check("coin_ack_t",   32'(last_ack), 32'd16128);
        clear_stats();
        run_to(16384);
        check("coin_hi0_100", 32'(hi[0]), 32'd100);
        check("coin_ack2",    32'(acks),  32'd1);
        clear_stats();
        run_to(16640);
        check("coin_hi0_50",  32'(hi[0]), 32'd50);
        check("coin_no_ack",  32'(acks),  32'd0);

        // 5c: load coincident with frame_start, nothing pending
        clear_stats();
        run_to(16895);
        load_cmd(6'b010101, 8'd255);
        check("np_no_ack",    32'(acks),  32'd0);
        check("np_hi0",       32'(hi[0]), 32'd50);
        clear_stats();
        run_to(17152);
        check("np_hi0_next",  32'(hi[0]),    32'd50);
        check("np_ack",       32'(acks),     32'd1);
        check("np_ack_t",     32'(last_ack), 32'd17152);

        // 6: reset mid-blink with a load pending (and a load during reset)
        load_cmd(6'b001110, 8'd255);
        run_to(17500);
        check("pre_rst_lamp", 32'(lamp), 32'd2);
        load_cmd(6'b010101, 8'd255);
        rstb = 1'b1;
        load = 1'b1;
        mode = 6'b010101;
        duty = 8'd128;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_lamp",  32'(lamp),  32'd0);
        check("mid_rst_ack",   32'(ack),   32'd0);
        check("mid_rst_frame", 32'(frame), 32'd0);
        rstb = 1'b0;
        load = 1'b0;
        t = 0;
        clear_stats();
        run_to(600);
        check("post_rst_hi",     32'(hi[0] + hi[1] + hi[2]), 32'd0);
        check("post_rst_acks",   32'(acks),        32'd0);
        check("post_rst_frames", 32'(frames),      32'd2);
        check("post_rst_first",  32'(first_frame), 32'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
